// File: rtl/output_allocator.sv
// Round-robin output-port allocator: arbitrates NREQ forwarding requests into a
// two-entry VC buffer selected by the global polarity, rewriting the hop field.
module output_allocator #(
  parameter int NREQ = 4,
  parameter int DW   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               polarity_i,
  input  logic [NREQ-1:0]    req_v_i,
  input  logic [NREQ*DW-1:0] req_d_i,
  output logic [NREQ-1:0]    req_gnt_o,
  output logic               so_o,
  input  logic               ro_i,
  output logic [DW-1:0]      do_o,
  output logic [1:0]         vc_full_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [DW-1:0]   buf_q [2];
  logic [DW-1:0]   buf_d [2];
  logic [1:0]      full_q, full_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] gnt_s;
  logic [PW-1:0]   gnt_idx_s;
  logic            gnt_v_s;
  logic            fill_sel_s;
  logic            arb_en_s;

  // Hop field [55:48] moves one place right with a zero shifted in.
  function automatic logic [DW-1:0] hop_shift(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r        = d;
    r[55:48] = {1'b0, d[55:49]};
    return r;
  endfunction

  assign fill_sel_s = ~polarity_i;
  assign arb_en_s   = ~reset & ~full_q[fill_sel_s];

  // Circular search from rr_ptr for the first requesting port.
  always_comb begin
    logic [PW:0] idx_v;
    gnt_s     = '0;
    gnt_idx_s = '0;
    gnt_v_s   = 1'b0;
    idx_v     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx_v >= (PW+1)'(NREQ)) begin
        idx_v = idx_v - (PW+1)'(NREQ);
      end else begin
        idx_v = idx_v;
      end
      if (arb_en_s && !gnt_v_s && req_v_i[idx_v[PW-1:0]]) begin
        gnt_v_s   = 1'b1;
        gnt_idx_s = idx_v[PW-1:0];
      end else begin
        gnt_v_s   = gnt_v_s;
      end
    end
    if (gnt_v_s) begin
      gnt_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Drain and fill always touch opposite buffers, so both may update together.
  always_comb begin
    full_d   = full_q;
    rr_ptr_d = rr_ptr_q;
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    if (reset) begin
      full_d   = 2'b00;
      rr_ptr_d = '0;
      buf_d[0] = '0;
      buf_d[1] = '0;
    end else begin
      if (full_q[polarity_i] && ro_i) begin
        full_d[polarity_i] = 1'b0;
      end else begin
        full_d[polarity_i] = full_q[polarity_i];
      end
      if (gnt_v_s) begin
        buf_d[fill_sel_s]  = hop_shift(req_d_i[gnt_idx_s*DW +: DW]);
        full_d[fill_sel_s] = 1'b1;
        rr_ptr_d = (gnt_idx_s == PW'(NREQ-1)) ? '0 : gnt_idx_s + PW'(1);
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    full_q   <= full_d;
    rr_ptr_q <= rr_ptr_d;
    buf_q[0] <= buf_d[0];
    buf_q[1] <= buf_d[1];
  end

  assign req_gnt_o = gnt_s;
  assign so_o      = full_q[polarity_i];
  assign do_o      = buf_q[polarity_i];
  assign vc_full_o = full_q;

endmodule

// File: doc/output_allocator.md
# output_allocator

Round-robin output-port allocator for the CMP router. It arbitrates up to NREQ input-port forwarding requests onto one output link. It holds one flit per virtual channel (VC), with VC selection set by the global `polarity` signal, and rewrites the hop field of each accepted flit. It sits between the input-port routing stages and the inter-router link, and it sequences all writes into and reads out of the per-VC output buffers.

## Interface
- `NREQ`, default 4: number of requesting input ports (2..8).
- `DW`, default 64: flit width. Bits [55:48] are the hop field.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `polarity`  in  1  global VC phase; toggles every cycle, driven externally
- `req_v`  in  NREQ  per-port forward-request valid
- `req_d`  in  NREQ*DW  per-port flit; port i occupies [i*DW +: DW]
- `req_gnt`  out  NREQ  one-hot grant; flit of the granted port is accepted this cycle
- `so`  out  1  output send-valid for VC `polarity`
- `ro`  in  1  downstream ready for VC `polarity`
- `do`  out  DW  output flit of VC `polarity`
- `vc_full`  out  2  occupancy of VC buffers [1:0], for status and debug

## Operation
- Two buffers, `buf[0]` and `buf[1]`, each with a `full` bit.
- **Fill side:** writes only target `buf[~polarity]`.
  - Arbitration is enabled only when `full[~polarity]==0`.
- **Drain side:** `so = full[polarity]` and `do = buf[polarity]`.
  - When `so && ro`, clear `full[polarity]` at the clock edge.
- **Round-robin arbitration:**
  - Pointer `rr_ptr`, width log2(NREQ).
  - Search `req_v` starting at index `rr_ptr`, ascending, wrapping modulo NREQ.
  - Grant the first set bit; `req_gnt` is combinational.
  - At most one grant bit is high in any cycle.
  - No grant when the target buffer is full or when `req_v==0`.
- **Pointer update:** on a grant to port i, `rr_ptr <= (i+1) mod NREQ`. With no grant, `rr_ptr` holds.
- **Hop-field rewrite on accept:**
  - Stored flit = `{d[63:56], 1'b0, d[55:49], d[47:0]}`, i.e. hop field shifted right by one with zero fill.
  - All other bits pass unchanged.
  - Then set `full[~polarity]`.
- **Simultaneous fill and drain:** always legal, because they target opposite buffers.
- **Requester contract:** a requester must hold `req_v`/`req_d` stable until it is granted. Dropping `req_v` before a grant is allowed; no flit is accepted in that case.
- **Reset:** `reset` overrides all other updates in the same cycle.
  - `full=2'b00`, `rr_ptr=0`, both buffers cleared to 0.
  - Outputs read `so=0`, `do=0`, `vc_full=0`, `req_gnt=0`.
- **Reset mid-operation:** in-flight flits are discarded without a drain handshake. In the reset cycle `req_gnt` is forced to 0.

## Timing
- Grant-to-store is 1 cycle. A flit granted in the cycle with `polarity=p` is in `buf[~p]` after the edge.
- Because `polarity` toggles, `so` asserts in the very next cycle, so minimum request-to-`so` latency is 1 cycle.
- `so`/`do` are pure functions of registered state plus `polarity`; there is no combinational path from `ro`.
- `req_gnt` depends combinationally on `req_v`, `polarity`, `full` and `rr_ptr`. It has no dependency on `ro`.
- Throughput: one flit per cycle sustained when downstream asserts `ro` in every `so` cycle.
- If `ro` stays low, the affected VC remains full and new grants stop on every cycle whose `polarity` targets that VC. The other VC keeps operating.

## Test plan
- **Single requester:**
  - Stimulus: reset, then `req_v=4'b0100`, `req_d[2]=64'hAB_FF_0000_1234_5678` (hop field 8'hFF), with `ro=1`.
  - Required: `req_gnt=4'b0100` in the same cycle; the next cycle shows `so=1` and `do=64'hAB_7F_0000_1234_5678`.
  - After that, `full` clears.
- **Fairness:**
  - Stimulus: all four `req_v` held high, `ro=1`.
  - Required: grants appear in order ports 0, 1, 2, 3, 0 on consecutive cycles, with no port granted twice before the others.
- **Backpressure:**
  - Stimulus: `ro=0`; fill both VCs.
  - Required: `vc_full=2'b11`, `req_gnt=0` thereafter, and `rr_ptr` frozen.
  - Then raise `ro` for one `so` cycle: exactly that VC drains, and the next opposite-phase grant resumes at the frozen pointer.
- **Simultaneous fill and drain:**
  - Stimulus: `buf[p]` full, `ro=1`, a request pending while `polarity=p`.
  - Required: at the edge `full[p]` clears and `full[~p]` sets in the same cycle.
- **Reset mid-operation:**
  - Stimulus: assert `reset` for 1 cycle with both VCs full and requests pending.
  - Required: in that cycle `req_gnt=0`. Next cycle shows `so=0`, `do=0`, `vc_full=0`, and a subsequent grant goes to the lowest requesting port.
- **Wrap-around:**
  - Stimulus: `rr_ptr=3`, `req_v=4'b1001`.
  - Required: grant port 3 with `rr_ptr` becoming 0; the next grant goes to port 0.
